mch_playback_unit: RTL and testbench
====================================

# mch_playback_unit

Multi-channel successor to the single-bit channel unit: stores an N_CH-wide pattern in external block RAM and replays it on N_CH parallel outputs. Playback runs between programmable start and stop addresses, one sample per rate strobe, with loop, wrap-around, per-channel masking and idle levels. It sits between the AXI-lite register block, which drives the control pulses, and the BRAM port (addra/dina/douta/wea). Everything runs in the AXI clock domain; the separate playback clock of the previous generation is replaced by a clock-enable strobe.

## Interface
- N_ADDR_BITS, 20, RAM address width
- DEPTH, 1048576, RAM depth in words (≤ 2^N_ADDR_BITS)
- N_CH, 8, channel count = RAM word width
- LOOP_CNT_BITS, 16, loop counter width (used only with the macro)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle playback-rate strobe; successive ticks ≥2 clk apart
- mode  in  1  0 = load, 1 = playback; sampled only in IDLE
- addr_in  in  N_ADDR_BITS  address operand
- set_start  in  1  pulse: start_addr ← addr_in, wptr ← addr_in
- set_stop  in  1  pulse: stop_addr ← addr_in
- w_ram  in  1  load mode: write din at wptr, then wptr+1
- din  in  N_CH  write data
- playback_en  in  1  level; rising edge in IDLE with mode=1 starts playback
- loop  in  1  repeat start..stop until playback_en drops
- loop_count  in  LOOP_CNT_BITS  extra passes (macro only)
- ch_mask  in  N_CH  1 = channel driven from RAM
- idle_level  in  N_CH  value on masked or inactive channels
- ch_out  out  N_CH  registered channel outputs
- busy  out  1  state ∈ {PRIME, RUN}
- playback_done  out  1  high in DONE
- addra  out  N_ADDR_BITS  RAM address (registered)
- dina  out  N_CH  RAM write data (registered)
- douta  in  N_CH  RAM read data, 1-cycle latency
- wea  out  1  RAM write enable (registered)

## Operation
- States: IDLE, PRIME, RUN, DONE.
- IDLE: set_start/set_stop are accepted only here. If mode=0 and w_ram=1, then next cycle wea=1, addra=wptr, dina=din, and wptr advances. wptr wraps DEPTH-1→0.
- IDLE→PRIME: playback_en rises while mode=1. addra←start_addr. The loop counter loads loop_count.
- PRIME: lasts exactly 1 cycle and ignores tick, then goes to RUN.
- RUN, on tick: ch_out ← (douta & ch_mask) | (idle_level & ~ch_mask).
  - If addra≠stop_addr: addra←addra+1, wrapping DEPTH-1→0. A stop address below the start address therefore plays through the wrap.
  - If addra=stop_addr and loop=1 (and the counter is ≠0 or the pass is infinite): addra←start_addr and the counter decrements. Otherwise go to DONE.
- start_addr=stop_addr: every pass is a single sample.
- DONE: ch_out=idle_level and playback_done=1. DONE→IDLE when playback_en=0.
- playback_en=0 in PRIME or RUN aborts to IDLE. ch_out=idle_level on the next cycle.
- tick and abort in the same cycle: the abort wins and no sample is output.
- set_*/w_ram outside IDLE are ignored. mode changes outside IDLE have no effect.

## Timing
- Reset values: ch_out=0, busy=0, playback_done=0, addra=0, dina=0, wea=0. start_addr, stop_addr and wptr reset to 0. State resets to IDLE.
- Write latency: w_ram at cycle n → wea/addra/dina at n+1.
- Start latency: playback_en rise at n → PRIME at n+1 (addra=start_addr) → RUN at n+2. The first tick is honoured at ≥n+2.
- Sample latency: tick at cycle n → ch_out valid at n+1. addra advances at n+1, and douta for the new address is valid at n+2.
- DONE is entered on the cycle after the final tick. playback_done is high from that same cycle.
- reset_n low mid-operation clears everything asynchronously. There is no partial write: wea drops immediately.

## Configuration
- MCH_PLAYBACK_LOOP_COUNT_EN defined:
  - loop=1 with loop_count=N>0 plays N+1 passes, then DONE.
  - loop_count=0 with loop=1 loops forever.
- Undefined: loop_count is ignored, there is no counter logic, and loop=1 always loops forever.

## Test plan
- Load: set_start addr_in=0x10, then w_ram ×4 with din=0xA1,0xB2,0xC3,0xD4 → wea pulses at addresses 0x10..0x13 with matching dina; wptr ends at 0x14.
- One-shot: start=0x10, stop=0x13, mask=0xFF, loop=0, ticks every 4 clk → ch_out A1,B2,C3,D4; playback_done rises the cycle after the 4th tick and stays high until playback_en=0.
- Mask/idle: repeat the one-shot with mask=0x0F, idle=0x50 → ch_out 0x51,0x52,0x53,0x54.
- Wrap: DEPTH=16, start=14, stop=1 → address sequence 14,15,0,1, then DONE.
- Abort: drop playback_en after the 2nd tick, with a tick in the same cycle → ch_out=idle_level next cycle, state IDLE, no 3rd sample.
- Loop count (macro on): loop=1, loop_count=2, start=stop=0x10 → exactly 3 samples of A1, then DONE. With the macro off, samples continue until playback_en=0.

Source files
------------

// File: rtl/mch_playback_unit_if.sv
// mch_playback_unit_if: single-port block-RAM bus between the playback unit
// (master) and the pattern RAM (slave). douta has one cycle of read latency.
interface mch_playback_unit_if #(
   parameter int N_ADDR_BITS = 20,
   parameter int N_CH        = 8
);
   logic [N_ADDR_BITS-1:0] addra;
   logic [N_CH-1:0]        dina;
   logic [N_CH-1:0]        douta;
   logic                   wea;

   modport master (
      output addra,
      output dina,
      output wea,
      input  douta
   );

   modport slave (
      input  addra,
      input  dina,
      input  wea,
      output douta
   );
endinterface

// File: rtl/mch_playback_unit.sv
// mch_playback_unit: stores an N_CH-wide pattern in external block RAM and
// replays it on N_CH parallel outputs between programmable start and stop
// addresses, one sample per tick strobe, with loop, wrap-around, per-channel
// masking and idle levels.
// Optional feature: define MCH_PLAYBACK_LOOP_COUNT_EN to bound looping to
// loop_count+1 passes (loop_count=0 keeps looping until playback_en drops).
module mch_playback_unit #(
   parameter int N_ADDR_BITS   = 20,
   parameter int DEPTH         = 1048576,
   parameter int N_CH          = 8,
   parameter int LOOP_CNT_BITS = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     tick,
   input  logic                     mode,
   input  logic [N_ADDR_BITS-1:0]   addr_in,
   input  logic                     set_start,
   input  logic                     set_stop,
   input  logic                     w_ram,
   input  logic [N_CH-1:0]          din,
   input  logic                     playback_en,
   input  logic                     loop,
   input  logic [LOOP_CNT_BITS-1:0] loop_count,
   input  logic [N_CH-1:0]          ch_mask,
   input  logic [N_CH-1:0]          idle_level,
   output logic [N_CH-1:0]          ch_out,
   output logic                     busy,
   output logic                     playback_done,
   mch_playback_unit_if.master      ram
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Highest valid RAM word; addresses wrap from here back to zero.
   localparam logic [N_ADDR_BITS-1:0] LAST_ADDR = N_ADDR_BITS'(DEPTH - 1);

   state_t                 state_q, state_d;
   logic [N_ADDR_BITS-1:0] start_addr_q, start_addr_d;
   logic [N_ADDR_BITS-1:0] stop_addr_q, stop_addr_d;
   logic [N_ADDR_BITS-1:0] wptr_q, wptr_d;
   logic [N_ADDR_BITS-1:0] addra_q, addra_d;
   logic [N_CH-1:0]        dina_q, dina_d;
   logic [N_CH-1:0]        ch_out_q, ch_out_d;
   logic                   wea_q, wea_d;
   logic                   en_q, en_d;
   logic                   repeat_ok;
   logic [N_CH-1:0]        ch_sample;

`ifdef MCH_PLAYBACK_LOOP_COUNT_EN
   logic [LOOP_CNT_BITS-1:0] loop_cnt_q, loop_cnt_d;
   logic                     loop_inf_q, loop_inf_d;
`else
   // Without the bounded-loop feature the count operand has no function.
   logic unused_loop_count;
   assign unused_loop_count = ^loop_count;
`endif

   // Address successor with explicit wrap, so non-power-of-two depths work.
   function automatic logic [N_ADDR_BITS-1:0] next_addr(input logic [N_ADDR_BITS-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + N_ADDR_BITS'(1);
   endfunction

   // Next-state, RAM-port and channel-output logic for the playback FSM.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d      = state_q;
      start_addr_d = start_addr_q;
      stop_addr_d  = stop_addr_q;
      wptr_d       = wptr_q;
      addra_d      = addra_q;
      dina_d       = dina_q;
      wea_d        = 1'b0;
      ch_out_d     = ch_out_q;
      en_d         = playback_en;
      ch_sample    = (ram.douta & ch_mask) | (idle_level & ~ch_mask);
`ifdef MCH_PLAYBACK_LOOP_COUNT_EN
      loop_cnt_d   = loop_cnt_q;
      loop_inf_d   = loop_inf_q;
      repeat_ok    = loop & (loop_inf_q | (loop_cnt_q != '0));
`else
      repeat_ok    = loop;
`endif

      unique case (state_q)
         S_IDLE: begin
            ch_out_d = idle_level;
            if (set_stop) begin
               stop_addr_d = addr_in;
            end
            if (!mode && w_ram) begin
               // The write goes to the pointer as it stood at the request.
               wea_d   = 1'b1;
               addra_d = wptr_q;
               dina_d  = din;
               wptr_d  = next_addr(wptr_q);
            end else if (mode && playback_en && !en_q) begin
               state_d = S_PRIME;
               addra_d = start_addr_q;
`ifdef MCH_PLAYBACK_LOOP_COUNT_EN
               loop_cnt_d = loop_count;
               loop_inf_d = (loop_count == '0);
`endif
            end
            // A new start address also re-bases the load pointer.
            if (set_start) begin
               start_addr_d = addr_in;
               wptr_d       = addr_in;
            end
         end

         S_PRIME: begin
            // One cycle for the RAM to present the start word; tick is ignored.
            ch_out_d = idle_level;
            state_d  = playback_en ? S_RUN : S_IDLE;
         end

         S_RUN: begin
            if (!playback_en) begin
               // Abort beats a coincident tick: no sample is emitted.
               state_d  = S_IDLE;
               ch_out_d = idle_level;
            end else if (tick) begin
               ch_out_d = ch_sample;
               if (addra_q != stop_addr_q) begin
                  addra_d = next_addr(addra_q);
               end else if (repeat_ok) begin
                  addra_d = start_addr_q;
`ifdef MCH_PLAYBACK_LOOP_COUNT_EN
                  if (!loop_inf_q) begin
                     loop_cnt_d = loop_cnt_q - LOOP_CNT_BITS'(1);
                  end
`endif
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            ch_out_d = idle_level;
            if (!playback_en) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by reset_n.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         start_addr_q <= '0;
         stop_addr_q  <= '0;
         wptr_q       <= '0;
         addra_q      <= '0;
         dina_q       <= '0;
         wea_q        <= 1'b0;
         ch_out_q     <= '0;
         en_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register here update from
         // the same pre-edge values, independent of statement order.
         state_q      <= state_d;
         start_addr_q <= start_addr_d;
         stop_addr_q  <= stop_addr_d;
         wptr_q       <= wptr_d;
         addra_q      <= addra_d;
         dina_q       <= dina_d;
         wea_q        <= wea_d;
         ch_out_q     <= ch_out_d;
         en_q         <= en_d;
      end
   end

`ifdef MCH_PLAYBACK_LOOP_COUNT_EN
   // Remaining extra passes and the endless-loop flag captured at start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         loop_cnt_q <= '0;
         loop_inf_q <= 1'b0;
      end else begin
         loop_cnt_q <= loop_cnt_d;
         loop_inf_q <= loop_inf_d;
      end
   end
`endif

   assign ch_out        = ch_out_q;
   assign busy          = (state_q == S_PRIME) || (state_q == S_RUN);
   assign playback_done = (state_q == S_DONE);
   assign ram.addra     = addra_q;
   assign ram.dina      = dina_q;
   assign ram.wea       = wea_q;

endmodule

// File: tb/tb_mch_playback_unit.sv
// tb_mch_playback_unit: directed and randomized checks of mch_playback_unit
// against a sample-sequence reference model and a simple RAM model.
module tb_mch_playback_unit;
   localparam int AW    = 8;
   localparam int DEPTH = 24;
   localparam int NCH   = 8;
   localparam int LCB   = 16;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            tick = 1'b0;
   logic            mode = 1'b0;
   logic            set_start = 1'b0;
   logic            set_stop = 1'b0;
   logic            w_ram = 1'b0;
   logic            playback_en = 1'b0;
   logic            loop = 1'b0;
   logic [AW-1:0]   addr_in = '0;
   logic [NCH-1:0]  din = '0;
   logic [NCH-1:0]  ch_mask = '0;
   logic [NCH-1:0]  idle_level = '0;
   logic [LCB-1:0]  loop_count = '0;
   logic [NCH-1:0]  ch_out;
   logic            busy;
   logic            playback_done;

   int              n_tests = 0;
   int              n_fail  = 0;

   logic [NCH-1:0]  ram_mem [DEPTH];
   logic [NCH-1:0]  exp_mem [DEPTH];

   mch_playback_unit_if #(.N_ADDR_BITS(AW), .N_CH(NCH)) bus ();

   mch_playback_unit #(
      .N_ADDR_BITS(AW), .DEPTH(DEPTH), .N_CH(NCH), .LOOP_CNT_BITS(LCB)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .mode(mode),
      .addr_in(addr_in), .set_start(set_start), .set_stop(set_stop),
      .w_ram(w_ram), .din(din), .playback_en(playback_en), .loop(loop),
      .loop_count(loop_count), .ch_mask(ch_mask), .idle_level(idle_level),
      .ch_out(ch_out), .busy(busy), .playback_done(playback_done),
      .ram(bus)
   );

   always #5 clk = ~clk;

   // Block RAM model: write-enable port plus registered read.
   always @(posedge clk) begin
      if (bus.wea) ram_mem[int'(bus.addra)] <= bus.dina;
      bus.douta <= ram_mem[int'(bus.addra)];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Number of passes a playback makes; 0 means it never ends on its own.
   function automatic int passes(input bit lp, input int lc);
      int p;
      p = lp ? 0 : 1;
`ifdef MCH_PLAYBACK_LOOP_COUNT_EN
      if (lp && lc != 0) p = lc + 1;
`else
      if (lc < 0) p = 1;
`endif
      return p;
   endfunction

   task automatic write_word(input logic [7:0] data, input int waddr);
      mode = 1'b0; w_ram = 1'b1; din = data;
      step();
      w_ram = 1'b0;
      exp_mem[waddr] = data;
      check("wr_wea", 32'(bus.wea), 1);
      check("wr_addra", 32'(bus.addra), waddr);
      check("wr_dina", 32'(bus.dina), 32'(data));
   endtask

   task automatic set_ptrs(input int start, input int stop);
      addr_in = AW'(stop); set_stop = 1'b1;
      step();
      set_stop = 1'b0; addr_in = AW'(start); set_start = 1'b1;
      step();
      set_start = 1'b0;
   endtask

   // One playback from the model's point of view: the expected address walk
   // from start to stop (modulo DEPTH), repeated for the number of passes.
   // abort_at >= 0 drops playback_en together with that sample's tick.
   task automatic play(input string tag, input int start, input int stop, input bit lp,
                       input int lc, input logic [7:0] mask, input logic [7:0] idle,
                       input int abort_at);
      int addrs[$];
      int np, total, a;
      logic [7:0] exp_v;
      ch_mask = mask; idle_level = idle; loop = lp; loop_count = LCB'(lc);
      set_ptrs(start, stop);
      np = passes(lp, lc);
      total = (np == 0) ? abort_at + 1 : np * (((stop - start + DEPTH) % DEPTH) + 1);
      a = start;
      for (int i = 0; i <= total; i++) begin
         addrs.push_back(a);
         a = (a == stop) ? start : (a + 1) % DEPTH;
      end

      mode = 1'b1; playback_en = 1'b1;
      step();
      check({tag, "_prime_busy"}, 32'(busy), 1);
      check({tag, "_prime_addra"}, 32'(bus.addra), start);
      tick = 1'b1;
      step();
      tick = 1'b0;
      check({tag, "_prime_tick_ignored"}, 32'(bus.addra), start);
      check({tag, "_run_idle_out"}, 32'(ch_out), 32'(idle));

      for (int i = 0; i < total; i++) begin
         step();
         repeat ($urandom_range(0, 2)) step();
         exp_v = (exp_mem[addrs[i]] & mask) | (idle & ~mask);
         if (i == abort_at) begin
            tick = 1'b1; playback_en = 1'b0;
            step();
            tick = 1'b0;
            check({tag, "_abort_out"}, 32'(ch_out), 32'(idle));
            check({tag, "_abort_busy"}, 32'(busy), 0);
            check({tag, "_abort_done"}, 32'(playback_done), 0);
            repeat (3) begin
               step(); tick = 1'b1; step(); tick = 1'b0;
            end
            check({tag, "_abort_no_sample"}, 32'(ch_out), 32'(idle));
            mode = 1'b0;
            return;
         end
         tick = 1'b1;
         step();
         tick = 1'b0;
         check({tag, "_sample"}, 32'(ch_out), 32'(exp_v));
         if (i == total - 1) begin
            check({tag, "_done_rise"}, 32'(playback_done), 1);
            check({tag, "_done_busy"}, 32'(busy), 0);
         end else begin
            check({tag, "_next_addra"}, 32'(bus.addra), addrs[i + 1]);
            check({tag, "_not_done"}, 32'(playback_done), 0);
         end
      end
      repeat (3) step();
      check({tag, "_done_hold"}, 32'(playback_done), 1);
      check({tag, "_done_idle_out"}, 32'(ch_out), 32'(idle));
      playback_en = 1'b0;
      step();
      check({tag, "_done_release"}, 32'(playback_done), 0);
      check({tag, "_idle_busy"}, 32'(busy), 0);
      mode = 1'b0;
   endtask

   initial begin
      int s, e;
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_ch_out", 32'(ch_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(playback_done), 0);
      check("rst_addra", 32'(bus.addra), 0);
      check("rst_dina", 32'(bus.dina), 0);
      check("rst_wea", 32'(bus.wea), 0);
      reset_n = 1'b1;
      step();

      // Directed load at 0x10; the fifth write proves wptr reached 0x14.
      addr_in = 8'h10; set_start = 1'b1;
      step();
      set_start = 1'b0;
      write_word(8'hA1, 8'h10);
      write_word(8'hB2, 8'h11);
      write_word(8'hC3, 8'h12);
      write_word(8'hD4, 8'h13);
      write_word(8'hE5, 8'h14);
      step();
      check("wr_wea_drop", 32'(bus.wea), 0);

      // Directed playbacks.
      play("oneshot", 8'h10, 8'h13, 1'b0, 0, 8'hFF, 8'h00, -1);
      play("mask", 8'h10, 8'h13, 1'b0, 0, 8'h0F, 8'h50, -1);
      play("abort", 8'h10, 8'h13, 1'b0, 0, 8'hFF, 8'h3C, 2);
      play("loopcnt", 8'h10, 8'h10, 1'b1, 2, 8'hFF, 8'h00, 6);
      play("loopinf", 8'h10, 8'h11, 1'b1, 0, 8'hF0, 8'h0A, 5);

      // Random full load starting at 20 so the write pointer wraps 23 -> 0.
      addr_in = 8'd20; set_start = 1'b1;
      step();
      set_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) write_word(8'($urandom), (20 + i) % DEPTH);
      step();

      // Wrap-around playback 22,23,0,1, then random one-shot ranges.
      play("wrap", DEPTH - 2, 1, 1'b0, 0, 8'hFF, 8'($urandom), -1);
      for (int k = 0; k < 5; k++) begin
         s = $urandom_range(0, DEPTH - 1);
         e = $urandom_range(0, DEPTH - 1);
         play("rand", s, e, 1'b0, 0, 8'($urandom), 8'($urandom), -1);
      end

      // Asynchronous reset in the middle of a write.
      idle_level = 8'hC3;
      step();
      mode = 1'b0; w_ram = 1'b1; din = 8'h77;
      step();
      w_ram = 1'b0;
      check("mid_wea_set", 32'(bus.wea), 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_wea", 32'(bus.wea), 0);
      check("arst_dina", 32'(bus.dina), 0);
      check("arst_addra", 32'(bus.addra), 0);
      check("arst_ch_out", 32'(ch_out), 0);
      check("arst_busy", 32'(busy), 0);
      reset_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
